// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: RV32I width codes and FSM encodings.
package lsu_pkg;

    // RV32I funct3 width codes used by loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Master FSM states
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/lsu_load_align.sv
// Extracts the addressed byte/halfword/word from a memory word and extends it.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] word,
    output logic [31:0] rdata
);

    logic [31:0] shifted;

    // Shift the addressed lane down to bit 0, then sign- or zero-extend it
    always_comb begin
        shifted = word >> {addr, 3'b000};
        rdata   = shifted;
        case (funct3)
            F3_B:    rdata = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   rdata = {24'h0, shifted[7:0]};
            F3_H:    rdata = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   rdata = {16'h0, shifted[15:0]};
            default: rdata = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator for the word-addressed data memory. One request is
// accepted per handshake, checked for legality, issued as a single-cycle
// strobe and answered through a valid/ready response port.
//
// Handshakes: a request transfers on a rising edge where req_valid and
// req_ready are both high; a response transfers on a rising edge where
// resp_valid and resp_ready are both high. Neither side may drop valid or
// change its payload while waiting for the other.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addy,
    output logic [31:0] mem_datain,
    output logic        mem_wen,
    output logic        mem_ren,
    output logic [3:0]  mem_byte_sel,
    input  logic [31:0] mem_dataout,
    output logic [1:0]  dbg_state
);

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    lsu_state_e  state;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;

    logic        f3_ok;
    logic        is_h;
    logic        is_w;
    logic        misaligned;
    logic        out_of_range;
    logic        req_legal;
    logic [3:0]  bsel_d;
    logic [31:0] din_d;
    logic [31:0] load_rdata;

    assign req_ready = (state == S_IDLE);
    assign dbg_state = state;

    // Classify the incoming request: width code, alignment, address range
    always_comb begin
        f3_ok = 1'b0;
        case (req_funct3)
            F3_B, F3_H, F3_W: f3_ok = 1'b1;
            F3_BU, F3_HU:     f3_ok = !req_we;
            default:          f3_ok = 1'b0;
        endcase
        is_h         = (req_funct3 == F3_H) || (req_funct3 == F3_HU);
        is_w         = (req_funct3 == F3_W);
        misaligned   = (is_h && req_addr[0]) || (is_w && (req_addr[1:0] != 2'b00));
        out_of_range = ({2'b00, req_addr[31:2]} >= DEPTH_W);
        req_legal    = f3_ok && !misaligned && !out_of_range;
    end

    // Store lane steering; loads always read the whole word
    always_comb begin
        bsel_d = 4'b1111;
        din_d  = req_wdata;
        if (req_we) begin
            case (req_funct3)
                F3_B: begin
                    bsel_d = 4'b0001 << req_addr[1:0];
                    din_d  = {4{req_wdata[7:0]}};
                end
                F3_H: begin
                    bsel_d = req_addr[1] ? 4'b1100 : 4'b0011;
                    din_d  = {2{req_wdata[15:0]}};
                end
                default: begin
                    bsel_d = 4'b1111;
                    din_d  = req_wdata;
                end
            endcase
        end
    end

    lsu_load_align u_align (
        .funct3 (f3_q),
        .addr   (off_q),
        .word   (mem_dataout),
        .rdata  (load_rdata)
    );

    // Request/access/response sequencer with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            we_q         <= 1'b0;
            f3_q         <= 3'b000;
            off_q        <= 2'b00;
            resp_valid   <= 1'b0;
            resp_rdata   <= 32'h0;
            resp_err     <= 1'b0;
            mem_ren      <= 1'b0;
            mem_wen      <= 1'b0;
            mem_addy     <= 32'h0;
            mem_datain   <= 32'h0;
            mem_byte_sel <= 4'b0000;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q         <= req_we;
                        f3_q         <= req_funct3;
                        off_q        <= req_addr[1:0];
                        mem_addy     <= {2'b00, req_addr[31:2]};
                        mem_datain   <= din_d;
                        mem_byte_sel <= bsel_d;
                        if (req_legal) begin
                            mem_ren <= !req_we;
                            mem_wen <= req_we;
                            state   <= S_ACCESS;
                        end else begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                            state      <= S_RESP;
                        end
                    end
                end
                S_ACCESS: begin
                    mem_ren    <= 1'b0;
                    mem_wen    <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= we_q ? 32'h0 : load_rdata;
                    state      <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= 32'h0;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    mem_ren <= 1'b0;
                    mem_wen <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a negedge-registered memory model.
module tb_lsu_mem_master;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addy;
    logic [31:0] mem_datain;
    logic        mem_wen;
    logic        mem_ren;
    logic [3:0]  mem_byte_sel;
    logic [31:0] mem_dataout;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    logic [31:0] mem [0:1023];

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_bsel;
        logic [31:0] exp_addy;
        logic [31:0] exp_din;
    } vec_t;

    vec_t vecs[$];

    lsu_mem_master #(.DEPTH(1024)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_addy     (mem_addy),
        .mem_datain   (mem_datain),
        .mem_wen      (mem_wen),
        .mem_ren      (mem_ren),
        .mem_byte_sel (mem_byte_sel),
        .mem_dataout  (mem_dataout),
        .dbg_state    (dbg_state)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: acts on the falling edge, read data registered
    always @(negedge clk) begin
        if (mem_wen) begin
            for (int b = 0; b < 4; b++)
                if (mem_byte_sel[b]) mem[mem_addy[9:0]][8*b +: 8] <= mem_datain[8*b +: 8];
        end
        if (mem_ren) mem_dataout <= mem[mem_addy[9:0]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic err, input logic [31:0] rdata,
                                input logic [3:0] bsel, input logic [31:0] addy, input logic [31:0] din);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.exp_err = err; v.exp_rdata = rdata; v.exp_bsel = bsel;
        v.exp_addy = addy; v.exp_din = din;
        return v;
    endfunction

    // Driver: present a request at #1 after an edge; returns #1 after the accepting edge
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        int n;
        n = 0;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("issue_ready_timeout", {31'b0, req_ready}, 32'h1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Apply one table record and check the response and memory-side fields
    task automatic run_vec(input vec_t v);
        logic [31:0] exp_rd;
        logic        seen_ren;
        logic        seen_wen;
        logic        busy_low;
        logic [3:0]  bsel;
        logic [31:0] addy;
        logic [31:0] din;
        int          lat;
        exp_q.push_back(v.exp_rdata);
        issue(v.we, v.f3, v.addr, v.wdata);
        bsel     = mem_byte_sel;
        addy     = mem_addy;
        din      = mem_datain;
        seen_ren = mem_ren;
        seen_wen = mem_wen;
        busy_low = !req_ready;
        lat      = 1;
        while (!resp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
            seen_ren = seen_ren | mem_ren;
            seen_wen = seen_wen | mem_wen;
            busy_low = busy_low & !req_ready;
        end
        chk("latency", 32'(lat), v.exp_err ? 32'd1 : 32'd2);
        chk("resp_err", {31'b0, resp_err}, {31'b0, v.exp_err});
        exp_rd = exp_q.pop_front();
        chk("resp_rdata", resp_rdata, exp_rd);
        chk("mem_ren_seen", {31'b0, seen_ren}, {31'b0, !v.exp_err && !v.we});
        chk("mem_wen_seen", {31'b0, seen_wen}, {31'b0, !v.exp_err && v.we});
        chk("req_ready_busy", {31'b0, busy_low}, 32'h1);
        if (!v.exp_err) begin
            chk("mem_byte_sel", {28'b0, bsel}, {28'b0, v.exp_bsel});
            chk("mem_addy", addy, v.exp_addy);
            if (v.we) chk("mem_datain", din, v.exp_din);
        end
        @(posedge clk); #1;
        chk("resp_valid_clear", {31'b0, resp_valid}, 32'h0);
        chk("req_ready_back", {31'b0, req_ready}, 32'h1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"},  {31'b0, req_ready},  32'h1);
        chk({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'h0);
        chk({tag, "_resp_rdata"}, resp_rdata,          32'h0);
        chk({tag, "_resp_err"},   {31'b0, resp_err},   32'h0);
        chk({tag, "_mem_ren"},    {31'b0, mem_ren},    32'h0);
        chk({tag, "_mem_wen"},    {31'b0, mem_wen},    32'h0);
        chk({tag, "_mem_addy"},   mem_addy,            32'h0);
        chk({tag, "_mem_datain"}, mem_datain,          32'h0);
        chk({tag, "_byte_sel"},   {28'b0, mem_byte_sel}, 32'h0);
        chk({tag, "_dbg_state"},  {30'b0, dbg_state},  32'h0);
    endtask

    initial begin
        int n;
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_funct3  = 3'b000;
        req_addr    = 32'h0;
        req_wdata   = 32'h0;
        resp_ready  = 1'b1;
        mem_dataout = 32'h0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[2] = 32'h80FF_7F01;
        mem[5] = 32'h1122_3344;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset in the middle of an SW access: the write must be suppressed
        issue(1'b1, 3'b010, 32'h14, 32'hDEAD_BEEF);
        chk("mid_sw_wen", {31'b0, mem_wen}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_ready", {31'b0, req_ready}, 32'h1);
        chk("word5_untouched", mem[5], 32'h1122_3344);

        // Directed vectors: we, f3, addr, wdata, err, rdata, byte_sel, addy, datain
        vecs.push_back(mk(1, 3'b000, 32'h16,   32'h1234_56AB, 0, 32'h0,         4'b0100, 32'd5,     32'hABAB_ABAB));
        vecs.push_back(mk(0, 3'b010, 32'h14,   32'h0,         0, 32'h11AB_3344, 4'b1111, 32'd5,     32'h0));
        vecs.push_back(mk(0, 3'b000, 32'h0A,   32'h0,         0, 32'hFFFF_FFFF, 4'b1111, 32'd2,     32'h0));
        vecs.push_back(mk(0, 3'b100, 32'h0B,   32'h0,         0, 32'h0000_0080, 4'b1111, 32'd2,     32'h0));
        vecs.push_back(mk(0, 3'b101, 32'h08,   32'h0,         0, 32'h0000_7F01, 4'b1111, 32'd2,     32'h0));
        vecs.push_back(mk(0, 3'b001, 32'h0A,   32'h0,         0, 32'hFFFF_80FF, 4'b1111, 32'd2,     32'h0));
        vecs.push_back(mk(0, 3'b010, 32'h08,   32'h0,         0, 32'h80FF_7F01, 4'b1111, 32'd2,     32'h0));
        vecs.push_back(mk(1, 3'b001, 32'h0E,   32'h1234_BEEF, 0, 32'h0,         4'b1100, 32'd3,     32'hBEEF_BEEF));
        vecs.push_back(mk(0, 3'b010, 32'h0C,   32'h0,         0, 32'hBEEF_0000, 4'b1111, 32'd3,     32'h0));
        vecs.push_back(mk(1, 3'b010, 32'h10,   32'hCAFE_F00D, 0, 32'h0,         4'b1111, 32'd4,     32'hCAFE_F00D));
        vecs.push_back(mk(0, 3'b000, 32'h10,   32'h0,         0, 32'h0000_000D, 4'b1111, 32'd4,     32'h0));
        vecs.push_back(mk(0, 3'b001, 32'h12,   32'h0,         0, 32'hFFFF_CAFE, 4'b1111, 32'd4,     32'h0));
        vecs.push_back(mk(1, 3'b000, 32'h13,   32'h0000_0077, 0, 32'h0,         4'b1000, 32'd4,     32'h7777_7777));
        vecs.push_back(mk(0, 3'b010, 32'h10,   32'h0,         0, 32'h77FE_F00D, 4'b1111, 32'd4,     32'h0));
        vecs.push_back(mk(1, 3'b010, 32'hFFC,  32'h5A5A_1234, 0, 32'h0,         4'b1111, 32'h3FF,   32'h5A5A_1234));
        vecs.push_back(mk(0, 3'b010, 32'hFFC,  32'h0,         0, 32'h5A5A_1234, 4'b1111, 32'h3FF,   32'h0));
        vecs.push_back(mk(0, 3'b010, 32'h06,   32'h0,         1, 32'h0,         4'b0000, 32'h0,     32'h0));
        vecs.push_back(mk(1, 3'b001, 32'h1001, 32'hFFFF,      1, 32'h0,         4'b0000, 32'h0,     32'h0));
        vecs.push_back(mk(0, 3'b010, 32'h1000, 32'h0,         1, 32'h0,         4'b0000, 32'h0,     32'h0));
        vecs.push_back(mk(0, 3'b011, 32'h00,   32'h0,         1, 32'h0,         4'b0000, 32'h0,     32'h0));
        vecs.push_back(mk(1, 3'b100, 32'h00,   32'hFF,        1, 32'h0,         4'b0000, 32'h0,     32'h0));
        vecs.push_back(mk(0, 3'b101, 32'h03,   32'h0,         1, 32'h0,         4'b0000, 32'h0,     32'h0));
        vecs.push_back(mk(0, 3'b010, 32'h02,   32'h0,         1, 32'h0,         4'b0000, 32'h0,     32'h0));
        vecs.push_back(mk(1, 3'b000, 32'h1000, 32'hFF,        1, 32'h0,         4'b0000, 32'h0,     32'h0));
        vecs.push_back(mk(0, 3'b010, 32'h00,   32'h0,         0, 32'h0,         4'b1111, 32'd0,     32'h0));

        foreach (vecs[i]) run_vec(vecs[i]);

        // Backpressure: LH held for 4 cycles while a second request waits
        resp_ready = 1'b0;
        issue(1'b0, 3'b001, 32'h08, 32'h0);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h08;
        req_wdata  = 32'h0;
        n = 0;
        while (!resp_valid && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_latency", 32'(n), 32'd1);
        chk("bp_rdata", resp_rdata, 32'h0000_7F01);
        chk("bp_err", {31'b0, resp_err}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("bp_valid_hold", {31'b0, resp_valid}, 32'h1);
            chk("bp_rdata_hold", resp_rdata, 32'h0000_7F01);
            chk("bp_ready_low", {31'b0, req_ready}, 32'h0);
            chk("bp_no_access", {31'b0, mem_ren}, 32'h0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_resp_done", {31'b0, resp_valid}, 32'h0);
        chk("bp_not_accepted", {31'b0, mem_ren}, 32'h0);
        chk("bp_ready_idle", {31'b0, req_ready}, 32'h1);
        @(posedge clk); #1;
        chk("bp_second_access", {31'b0, mem_ren}, 32'h1);
        chk("bp_second_busy", {31'b0, req_ready}, 32'h0);
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("bp_second_valid", {31'b0, resp_valid}, 32'h1);
        chk("bp_second_rdata", resp_rdata, 32'h80FF_7F01);
        @(posedge clk); #1;
        chk("bp_second_done", {31'b0, resp_valid}, 32'h0);

        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_mem_master.md
# lsu_mem_master

Load/store initiator that drives the word-addressed data-memory port (`memory_d`) on behalf of the core's MEM stage. It accepts one RV32I load or store request per handshake, converts the byte address into a word address, byte enables and lane-replicated write data, and issues a single-cycle read or write strobe. For loads it captures the memory's negedge-registered word and returns an extracted, sign- or zero-extended result through a valid/ready response port. Misaligned, out-of-range and illegal-width requests are rejected without touching memory.

## Interface
- `DEPTH`, default 1024: memory depth in 32-bit words. A word address ≥ DEPTH is out of range.
- `clk` in 1: single clock, rising-edge logic; the memory samples on the falling edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: high exactly when the FSM is in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I width code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer accepts the response.
- `resp_rdata` out 32: load result. It is 0 for stores and for errors.
- `resp_err` out 1: request rejected. No memory access took place.
- `mem_addy` out 32: word address, `{2'b0, req_addr[31:2]}`.
- `mem_datain` out 32: lane-replicated write data.
- `mem_wen`, `mem_ren` out 1 each: memory strobes. They are never high together.
- `mem_byte_sel` out 4: byte enables, bit n covers bits [8n+7:8n].
- `mem_dataout` in 32: memory read word.

## Operation
- The FSM has three states: IDLE, ACCESS and RESP.
- **IDLE:** On `req_valid & req_ready`, the block latches `we`, `funct3`, `addr[1:0]` and the derived memory fields.
  - If the request is legal, the FSM goes to ACCESS.
  - Otherwise the FSM goes to RESP with `resp_err=1`.
- **ACCESS:** Lasts exactly one cycle. Either `mem_ren=1` or `mem_wen=1`. At the end of the cycle a load captures `mem_dataout`. The FSM then goes to RESP.
- **RESP:** `resp_valid=1`, and `resp_rdata`/`resp_err` are held stable until `resp_ready`. The FSM then goes to IDLE.
- **Error conditions** (checked in this order, any one is sufficient):
  - illegal funct3: load 011/110/111, store anything other than 000–010;
  - misaligned: H with `addr[0]=1`, W with `addr[1:0]≠0`;
  - out of range: `addr[31:2] ≥ DEPTH`.
- **Store lanes:**
  - SB: `byte_sel = 4'b0001 << addr[1:0]`, `datain = {4{wdata[7:0]}}`.
  - SH: `byte_sel = addr[1] ? 4'b1100 : 4'b0011`, `datain = {2{wdata[15:0]}}`.
  - SW: `byte_sel = 4'b1111`, `datain = wdata`.
- **Loads:** `byte_sel = 4'b1111`. The result is `shifted = dataout >> (8*addr[1:0])`.
  - LB sign-extends `shifted[7:0]`; LBU zero-extends it.
  - LH sign-extends `shifted[15:0]`; LHU zero-extends it.
  - LW returns the full word.
- `mem_addy`, `mem_datain` and `mem_byte_sel` are registered at acceptance and held until the next acceptance. `mem_ren`/`mem_wen` are 0 outside ACCESS.

## Timing
- **Reset values:** state IDLE, so `req_ready=1`. `resp_valid=0`, `resp_rdata=0`, `resp_err=0`, `mem_ren=0`, `mem_wen=0`, `mem_addy=0`, `mem_datain=0`, `mem_byte_sel=0`.
- **Sequence:**
  - Acceptance at rising edge 0.
  - ACCESS occupies cycle 1. The memory acts at the falling edge inside cycle 1.
  - Load data is captured at rising edge 2.
  - `resp_valid` is high from cycle 2.
  - Latency is 2 cycles for legal requests and 1 cycle for errors.
  - Peak throughput is one request per 3 cycles, or per 2 for errors.
- **Backpressure:** `req_ready` is low in ACCESS and RESP. A request is never accepted in the same cycle that a response completes.
- **Reset mid-operation:** `rst_n` low forces all outputs to reset values immediately, asynchronously. If `mem_wen` falls before the falling edge of the ACCESS cycle, no write occurs. A pending response is discarded.
- `req_valid` while `req_ready=0` is ignored. The requester must hold its request.

## Structure
- Shared include/package `lsu_pkg`:
  - funct3 width constants `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`;
  - FSM state encodings `S_IDLE`, `S_ACCESS`, `S_RESP` (2 bits).
- One combinational sub-module, `lsu_load_align`, with inputs `funct3`, `addr[1:0]`, `word` and output `rdata`. It performs the shift and sign/zero extension.
- Store lane generation and the FSM stay in the top module.

## Test plan
- **Reset:** Assert `rst_n=0` mid-ACCESS of an SW → `mem_wen` drops at once, all outputs read their reset values, `req_ready=1` after release, and memory word 5 is unchanged.
- **SB:** `addr=0x0000_0016`, `wdata=0x1234_56AB` → `mem_addy=5`, `byte_sel=0100`, `datain=0xABAB_ABAB`. A following LW at `0x14` returns bits [23:16]=`0xAB`, other bytes preserved.
- **LB / LBU:** Word 2 = `0x80FF_7F01`; LB at `0x0A` → `0xFFFF_FFFF`; LBU at `0x0B` → `0x0000_0080`; LHU at `0x08` → `0x0000_7F01`. Each has `resp_valid` two cycles after acceptance.
- **Errors:**
  - LW at `0x0000_0006` → `resp_err=1`, `mem_ren` never high.
  - SH at `0x0000_1001` → error.
  - LW at word 1024 (`0x1000`) → error.
  - funct3=011 load → error.
  - Each has `resp_rdata=0` and latency 1.
- **Backpressure:** Hold `resp_ready=0` for 4 cycles after an LH → `resp_valid` and `resp_rdata` stay stable, `req_ready=0`, and a second `req_valid` is not accepted until the cycle after `resp_ready=1`.
